// File: rtl/core_pkg.sv
// Shared RV32I core definitions: sequencer state encoding and default
// reset vector / fetch timeout values.
package core_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    FAULT = 2'd2
  } seq_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEFAULT_TIMEOUT      = 255;

  // Counter width able to hold the value `limit` itself.
  function automatic int timerWidth(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch and datapath bundle between pc_sequencer (master) and the
// instruction memory / datapath (slave). trap_pc exists with PC_MISALIGN_TRAP_EN.
interface pc_sequencer_if #(
  parameter int N     = 32,
  parameter int CNT_W = 32
);

  logic             imem_req;
  logic [N-1:0]     imem_addr;
  logic             imem_ready;
  logic [N-1:0]     imem_rdata;
  logic [N-1:0]     instr;
  logic             instr_valid;
  logic             retire;
  logic             stall;
  logic             PCSrc;
  logic [N-1:0]     pc_target;
  logic [N-1:0]     pc;
  logic [N-1:0]     pc_plus4;
  logic [CNT_W-1:0] instret;
  logic             fault;
`ifdef PC_MISALIGN_TRAP_EN
  logic [N-1:0]     trap_pc;
`endif

  modport master (
`ifdef PC_MISALIGN_TRAP_EN
    output trap_pc,
`endif
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, instret, fault,
    input  imem_ready, imem_rdata, retire, stall, PCSrc, pc_target
  );

  modport slave (
`ifdef PC_MISALIGN_TRAP_EN
    input  trap_pc,
`endif
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, instret, fault,
    output imem_ready, imem_rdata, retire, stall, PCSrc, pc_target
  );

endinterface

// File: rtl/pc_sequencer_wait_timer.sv
// wait_timer: saturating cycle counter with clear/enable; expired_o flags the
// enabled cycle on which the count reaches LIMIT.
module wait_timer
  import core_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int           W    = timerWidth(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] MAX  = W'(LIMIT);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning the RV32I program counter.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned taken targets trap to FAULT.
module pc_sequencer
  import core_pkg::*;
#(
  parameter int           N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = N'(DEFAULT_RESET_VECTOR),
  parameter int           CNT_W        = 32,
  parameter int           TIMEOUT      = DEFAULT_TIMEOUT
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.master bus
);

  seq_state_t       state_q, state_d;
  logic [N-1:0]     pc_q, pc_d;
  logic [N-1:0]     instr_q, instr_d;
  logic             instrValid_q, instrValid_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [N-1:0]     pcPlus4, nextPc;
  logic             fetchDone, retireFire, timerExpired, trapHit;

  assign pcPlus4    = pc_q + N'(4);
  assign fetchDone  = (state_q == FETCH) && bus.imem_ready;
  assign retireFire = (state_q == EXEC) && bus.retire && !bus.stall;

  wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   ((state_q != FETCH) || bus.imem_ready),
    .enable_i  (state_q == FETCH),
    .expired_o (timerExpired)
  );

`ifdef PC_MISALIGN_TRAP_EN
  logic [N-1:0] trapPc_q, trapPc_d;

  assign trapHit = bus.PCSrc && (bus.pc_target[1:0] != 2'b00);
  assign nextPc  = bus.PCSrc ? bus.pc_target : pcPlus4;
`else
  assign trapHit = 1'b0;
  // Without the trap, taken targets are silently word-aligned.
  assign nextPc  = bus.PCSrc ? (bus.pc_target & ~N'(3)) : pcPlus4;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (bus.imem_ready) begin
          state_d = EXEC;
        end else if (timerExpired) begin
          state_d = FAULT;
        end
      end
      EXEC: begin
        if (retireFire) begin
          state_d = trapHit ? FAULT : FETCH;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.imem_req = 1'b0;
    bus.fault    = 1'b0;
    unique case (state_q)
      FETCH:   bus.imem_req = 1'b1;
      FAULT:   bus.fault    = 1'b1;
      default: ;
    endcase
  end

  // PCSrc/pc_target matter only in the retiring cycle; a trap freezes pc/instret.
  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    instrValid_d = instrValid_q;
    instret_d    = instret_q;
    if (fetchDone) begin
      instr_d      = bus.imem_rdata;
      instrValid_d = 1'b1;
    end
    if (retireFire) begin
      instrValid_d = 1'b0;
      if (!trapHit) begin
        pc_d      = nextPc;
        instret_d = instret_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      instr_q      <= '0;
      instrValid_q <= 1'b0;
      instret_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instrValid_q <= instrValid_d;
      instret_q    <= instret_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_comb begin
    trapPc_d = trapPc_q;
    if (retireFire && trapHit) begin
      trapPc_d = bus.pc_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trapPc_q <= '0;
    end else begin
      trapPc_q <= trapPc_d;
    end
  end

  assign bus.trap_pc = trapPc_q;
`endif

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pcPlus4;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instrValid_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural reference model checked every
// cycle plus directed vectors with literal expectations. Honours PC_MISALIGN_TRAP_EN.
module tb_pc_sequencer;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   checkEn;

  pc_sequencer_if #(.N(32), .CNT_W(TB_CNT_W)) bus ();

  pc_sequencer #(
    .N            (32),
    .RESET_VECTOR (32'h0000_0000),
    .CNT_W        (TB_CNT_W),
    .TIMEOUT      (TB_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = fetching, 1 = executing, 2 = faulted.
  int          mMode;
  int          mWait;
  int          mInstret;
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic        mValid;
  logic [31:0] mTrapPc;

  always @(posedge clk) begin
    if (reset) begin
      mMode = 0; mWait = 0; mInstret = 0;
      mPc = 32'h0; mInstr = 32'h0; mValid = 1'b0; mTrapPc = 32'h0;
    end else if (mMode == 0) begin
      if (bus.imem_ready) begin
        mInstr = bus.imem_rdata; mValid = 1'b1; mMode = 1; mWait = 0;
      end else begin
        mWait = mWait + 1;
        if (mWait >= TB_TIMEOUT) mMode = 2;
      end
    end else if (mMode == 1) begin
      if (bus.retire && !bus.stall) begin
        mValid = 1'b0;
        if (TRAP_EN && bus.PCSrc && (bus.pc_target % 4 != 0)) begin
          mMode = 2;
          mTrapPc = bus.pc_target;
        end else begin
          mPc = bus.PCSrc ? (bus.pc_target - (bus.pc_target % 4)) : (mPc + 32'd4);
          mInstret = (mInstret + 1) % (1 << TB_CNT_W);
          mMode = 0;
          mWait = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m_imem_req", 32'(bus.imem_req), 32'(mMode == 0));
      checkOutput("m_imem_addr", bus.imem_addr, mPc);
      checkOutput("m_pc", bus.pc, mPc);
      checkOutput("m_pc_plus4", bus.pc_plus4, mPc + 32'd4);
      checkOutput("m_instr", bus.instr, mInstr);
      checkOutput("m_instr_valid", 32'(bus.instr_valid), 32'(mValid));
      checkOutput("m_instret", 32'(bus.instret), 32'(mInstret));
      checkOutput("m_fault", 32'(bus.fault), 32'(mMode == 2));
`ifdef PC_MISALIGN_TRAP_EN
      checkOutput("m_trap_pc", bus.trap_pc, mTrapPc);
`endif
    end
  end

  // Drive one cycle of inputs, let the edge take them, then return inputs to idle.
  task automatic applyStimulus(input logic rdy, input logic [31:0] rdata, input logic ret,
                               input logic stl, input logic src, input logic [31:0] tgt);
    bus.imem_ready = rdy;
    bus.imem_rdata = rdata;
    bus.retire     = ret;
    bus.stall      = stl;
    bus.PCSrc      = src;
    bus.pc_target  = tgt;
    @(posedge clk);
    #1;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.retire     = 1'b0;
    bus.stall      = 1'b0;
    bus.PCSrc      = 1'b0;
    bus.pc_target  = 32'h0;
  endtask

  task automatic fetchInstr(input logic [31:0] word);
    applyStimulus(1'b1, word, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic retireInstr(input logic src, input logic [31:0] tgt);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, src, tgt);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    checkEn = 1'b0;
    reset = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0; bus.retire = 1'b0;
    bus.stall = 1'b0; bus.PCSrc = 1'b0; bus.pc_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkEn = 1'b1;

    checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd1);
    checkOutput("rst_imem_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_instr", bus.instr, 32'h0);
    checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rst_instret", 32'(bus.instret), 32'd0);
    checkOutput("rst_fault", 32'(bus.fault), 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("rst_trap_pc", bus.trap_pc, 32'h0);
`endif

    // First instruction: single-cycle fetch, retire next cycle.
    fetchInstr(32'h0050_0093);
    checkOutput("f1_valid", 32'(bus.instr_valid), 32'd1);
    checkOutput("f1_instr", bus.instr, 32'h0050_0093);
    checkOutput("f1_req", 32'(bus.imem_req), 32'd0);
    retireInstr(1'b0, 32'h0);
    checkOutput("r1_pc", bus.pc, 32'h4);
    checkOutput("r1_instret", 32'(bus.instret), 32'd1);
    checkOutput("r1_addr", bus.imem_addr, 32'h4);

    // Taken and not-taken branches.
    fetchInstr(32'h1); retireInstr(1'b1, 32'h10);
    checkOutput("br_to_10", bus.pc, 32'h10);
    fetchInstr(32'h2); retireInstr(1'b1, 32'h40);
    checkOutput("br_to_40", bus.imem_addr, 32'h40);
    fetchInstr(32'h3); retireInstr(1'b1, 32'h10);
    fetchInstr(32'h4); retireInstr(1'b0, 32'h80);
    checkOutput("nt_to_14", bus.imem_addr, 32'h14);

    // PCSrc outside the retiring cycle is ignored.
    fetchInstr(32'h5);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h80);
    checkOutput("idle_valid", 32'(bus.instr_valid), 32'd1);
    retireInstr(1'b0, 32'h80);
    checkOutput("idle_pc", bus.pc, 32'h18);
    checkOutput("idle_instret", 32'(bus.instret), 32'd6);

    // Stall masks retire; exactly one advance after release.
    fetchInstr(32'h0000_ABCD);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h100);
      checkOutput("stall_pc", bus.pc, 32'h18);
      checkOutput("stall_instr", bus.instr, 32'h0000_ABCD);
      checkOutput("stall_instret", 32'(bus.instret), 32'd6);
    end
    retireInstr(1'b0, 32'h0);
    checkOutput("unstall_pc", bus.pc, 32'h1C);
    checkOutput("unstall_instret", 32'(bus.instret), 32'd7);

    // PC wrap at top of address space.
    fetchInstr(32'h6); retireInstr(1'b1, 32'hFFFF_FFFC);
    checkOutput("top_pc", bus.pc, 32'hFFFF_FFFC);
    checkOutput("top_plus4", bus.pc_plus4, 32'h0);
    fetchInstr(32'h7); retireInstr(1'b0, 32'h0);
    checkOutput("wrap_pc", bus.pc, 32'h0);

    // Retired-instruction counter wrap.
    for (int i = 0; i < 20 && mInstret != (1 << TB_CNT_W) - 1; i++) begin
      fetchInstr(32'h8); retireInstr(1'b0, 32'h0);
    end
    checkOutput("instret_max", 32'(bus.instret), 32'hF);
    fetchInstr(32'h9); retireInstr(1'b0, 32'h0);
    checkOutput("instret_wrap", 32'(bus.instret), 32'h0);
    checkOutput("instret_wrap_pc", bus.pc, 32'h1C);

    // Misaligned taken target.
    fetchInstr(32'hA); retireInstr(1'b1, 32'h22);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("trap_fault", 32'(bus.fault), 32'd1);
    checkOutput("trap_pc", bus.trap_pc, 32'h22);
    checkOutput("trap_pc_held", bus.pc, 32'h1C);
    checkOutput("trap_instret", 32'(bus.instret), 32'd0);
    checkOutput("trap_valid", 32'(bus.instr_valid), 32'd0);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("trap_frozen_pc", bus.pc, 32'h1C);
    checkOutput("trap_frozen_req", 32'(bus.imem_req), 32'd0);
`else
    checkOutput("align_pc", bus.pc, 32'h20);
    checkOutput("align_fault", 32'(bus.fault), 32'd0);
    checkOutput("align_instret", 32'(bus.instret), 32'd1);
`endif

    // Reset from mid-operation, then fetch timeout.
    pulseReset();
    checkOutput("rst2_fault", 32'(bus.fault), 32'd0);
    checkOutput("rst2_pc", bus.pc, 32'h0);
    checkOutput("rst2_instret", 32'(bus.instret), 32'd0);
    for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("to_wait_fault", 32'(bus.fault), 32'd0);
      checkOutput("to_wait_req", 32'(bus.imem_req), 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("to_fault", 32'(bus.fault), 32'd1);
    checkOutput("to_req", 32'(bus.imem_req), 32'd0);
    applyStimulus(1'b1, 32'h1234, 1'b1, 1'b1, 1'b1, 32'h40);
    checkOutput("late_fault", 32'(bus.fault), 32'd1);
    checkOutput("late_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("late_pc", bus.pc, 32'h0);
    pulseReset();
    checkOutput("rst3_fault", 32'(bus.fault), 32'd0);
    checkOutput("rst3_req", 32'(bus.imem_req), 32'd1);

    @(negedge clk);
    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
